// File: rtl/shift_seq_if.sv
// Handshake and data bundle for shift_seq_unit.
// The control FSM drives the master side; the shifter is the slave.
interface shift_seq_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                  start;
  logic [2:0]            mode;
  logic [SELW-1:0]       amt_sel;
  logic [NSRC*SHW-1:0]   amt_src;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      data_out;
  logic [SHW-1:0]        amt_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, mode, amt_sel, amt_src, data_in,
    input  data_out, amt_out, busy, done
  );

  modport slave (
    input  start, mode, amt_sel, amt_src, data_in,
    output data_out, amt_out, busy, done
  );
endinterface

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR, one bit per clock) with a built-in
// shift-amount source selector, one source optionally forced to a constant.
module shift_seq_unit #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 4,
  parameter int CONST_IDX = 2,
  parameter int CONST_VAL = 16
) (
  input  logic        clk,
  input  logic        reset,
  shift_seq_if.slave  bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [SHW-1:0] CONST_AMT = SHW'(CONST_VAL);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       mode_r;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   amt_r;
  logic             busy_r;
  logic             done_r;

  logic [SHW-1:0]   amt_pick;
  logic [SHW-1:0]   amt_eff;
  logic             is_load;

  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] m,
                                                  input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] ds;
    ds = d;
    case (m)
      3'b001:  shift_step = {d[WIDTH-2:0], 1'b0};
      3'b010:  shift_step = {1'b0, d[WIDTH-1:1]};
      3'b011:  shift_step = $unsigned(ds >>> 1);
      3'b100:  shift_step = {d[0], d[WIDTH-1:1]};
      default: shift_step = d;
    endcase
  endfunction

  // Unselected or out-of-range selects fall through to an amount of 0.
  always_comb begin
    amt_pick = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.amt_sel == SELW'(i))
        amt_pick = (i == CONST_IDX) ? CONST_AMT : bus.amt_src[i*SHW +: SHW];
    end
  end

  assign is_load = !(bus.mode inside {3'b001, 3'b010, 3'b011, 3'b100});
  assign amt_eff = is_load ? '0 : amt_pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_r <= '0;
      cnt    <= '0;
      data_r <= '0;
      amt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            data_r <= bus.data_in;
            amt_r  <= amt_eff;
            mode_r <= bus.mode;
            cnt    <= amt_eff;
            busy_r <= 1'b1;
            if (amt_eff == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= SHIFT;
              done_r <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        SHIFT: begin
          data_r <= shift_step(mode_r, data_r);
          cnt    <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_r;
  assign bus.amt_out  = amt_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule
